inst_fetch_unit: RTL

Parametrised instruction-fetch front end. It holds the program counter and an internal synchronous-read instruction memory, and prefetches words into a small FIFO. Instructions are presented to the decode stage over a valid/ready handshake. A redirect port, driven by branch/jump resolution, flushes queued and in-flight fetches and restarts from a new address.

---
 rtl/ifetch_pkg.sv | 23 ++
 rtl/ifetch_fifo.sv | 68 ++++++
 rtl/inst_fetch_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and defaults for the instruction-fetch front end.
//   fetch_state_e  : issue-control FSM states
//   fetch_entry_t  : prefetch-queue entry {addr, data} at the default widths;
//                    the top redeclares the same layout at its own widths and
//                    hands it to the queue as a type parameter.
package ifetch_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous prefetch queue, first word presented at the head.
// Ports:
//   clka, rsta_n : clock, asynchronous active-low reset (pointers/count only)
//   flush        : discard all entries (wins over push/pop)
//   push, din    : write one entry
//   pop          : remove the head entry
//   dout         : head entry (meaningful only while count != 0)
//   count        : number of stored entries, 0..DEPTH
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int  DEPTH   = DEF_FIFO_DEPTH,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clka,
  input  logic             rsta_n,
  input  logic             flush,
  input  logic             push,
  input  entry_t           din,
  input  logic             pop,
  output entry_t           dout,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           slots_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is pure datapath and carries no reset.
  always_ff @(posedge clka) begin
    if (push && !flush) slots_q[wr_ptr_q] <= din;
  end

  assign dout  = slots_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction-fetch front end with program counter, internal
// synchronous-read instruction memory and a prefetch queue feeding decode.
// Ports:
//   clka, rsta_n        : clock, asynchronous active-low reset
//   redirect_valid/addr : flush queued and in-flight fetches, restart at addr
//   inst_valid/ready    : decode handshake; inst_data/inst_addr are the head
//   load_en/addr/data   : memory write port, present only when the macro
//                         INST_MEM_LOAD_EN is defined (otherwise ROM)
module inst_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int          DATA_W     = DEF_DATA_W,
  parameter int          ADDR_W     = DEF_ADDR_W,
  parameter int          FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned RESET_PC   = 0,
  parameter string       INIT_FILE  = ""
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr
`ifdef INST_MEM_LOAD_EN
  ,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
`endif
);

  localparam int               MEM_DEPTH = 1 << ADDR_W;
  localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              epoch_q, epoch_d;
  // vld_p1 is the in-flight flag: a read result sits in data_p1/addp_p1
  logic              vld_p1_q, vld_p1_d;
  logic              epoch_p1_q, epoch_p1_d;
  logic [ADDR_W-1:0] addr_p1_q;
  logic [DATA_W-1:0] data_p1_q;

  logic              issue, push, pop;
  logic [CNT_W-1:0]  fifo_count, count_next;
  logic [CNT_W:0]    credits_used, credits_next;
  entry_t            push_entry, head;

  // Memory image: zero-filled.
  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] = '0;
  end

`ifdef INST_MEM_LOAD_EN
  // Non-blocking write next to the registered read gives read-first behaviour.
  always_ff @(posedge clka) begin
    if (load_en) mem_q[load_addr] <= load_data;
  end
`endif

  always_comb begin
    pop          = inst_valid && inst_ready;
    // A result whose epoch predates a redirect is dropped, never queued.
    push         = vld_p1_q && (epoch_p1_q == epoch_q) && !redirect_valid;
    credits_used = {1'b0, fifo_count} + (CNT_W+1)'(vld_p1_q);
    // Credits ignore a same-cycle pop: the slot frees only after the edge.
    issue        = (state_q == S_RUN) && (credits_used < DEPTH_C) && !redirect_valid;

    pc_d       = pc_q;
    epoch_d    = epoch_q;
    vld_p1_d   = 1'b0;
    epoch_p1_d = epoch_p1_q;
    if (redirect_valid) begin
      pc_d    = redirect_addr;
      epoch_d = ~epoch_q;
    end else if (issue) begin
      pc_d       = pc_q + ADDR_W'(1);
      vld_p1_d   = 1'b1;
      epoch_p1_d = epoch_q;
    end

    count_next   = redirect_valid ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
    credits_next = {1'b0, count_next} + (CNT_W+1)'(vld_p1_d);

    // State follows next-cycle credits so HOLD never costs an issue slot.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN:  if (!redirect_valid && credits_next == DEPTH_C) state_d = S_HOLD;
      S_HOLD: if (redirect_valid || credits_next < DEPTH_C) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q    <= S_IDLE;
      pc_q       <= ADDR_W'(RESET_PC);
      epoch_q    <= 1'b0;
      vld_p1_q   <= 1'b0;
      epoch_p1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      vld_p1_q   <= vld_p1_d;
      epoch_p1_q <= epoch_p1_d;
    end
  end

  // ---- p0 -> p1: registered memory read ----
  always_ff @(posedge clka) begin
    if (issue) begin
      data_p1_q <= mem_q[pc_q];
      addr_p1_q <= pc_q;
    end
  end

  // ---- p1 -> queue ----
  always_comb begin
    push_entry.addr = addr_p1_q;
    push_entry.data = data_p1_q;
  end

  ifetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clka   (clka),
    .rsta_n (rsta_n),
    .flush  (redirect_valid),
    .push   (push),
    .din    (push_entry),
    .pop    (pop),
    .dout   (head),
    .count  (fifo_count)
  );

  // Queue storage is unreset, so outputs are forced to zero while empty.
  assign inst_valid = (fifo_count != '0);
  assign inst_data  = inst_valid ? head.data : '0;
  assign inst_addr  = inst_valid ? head.addr : '0;

endmodule
